fizzbuzz_ascii_streamer: RTL and testbench
==========================================

# fizzbuzz_ascii_streamer

Downstream stage of `fizz_buzz_counter`. Takes one classified event per count value (the `fizz`/`buzz`/`fizzbuzz` flags plus the counter value) and turns it into an ASCII line on a valid/ready byte stream: `Fizz\n`, `Buzz\n`, `FizzBuzz\n` or the decimal count followed by `\n`. A small event FIFO absorbs bursts from the free-running counter. A sticky flag records any event dropped because the FIFO was full.

## Interface
- `CNT_W`, default 8: width of `in_count`. Legal range 4..16.
- `DEPTH`, default 4: event FIFO depth. Power of two, at least 2.
- `DIGITS`, derived, not overridable: number of decimal digits of 2^CNT_W−1. This is 3 for the default.

- `clk`, input, 1: single clock, rising edge.
- `resetn`, input, 1: synchronous, active-low reset.
- `in_valid`, input, 1: event present this cycle.
- `in_ready`, output, 1: FIFO can accept an event.
- `in_fizz`, input, 1: count divisible by FIZZ.
- `in_buzz`, input, 1: count divisible by BUZZ.
- `in_fizzbuzz`, input, 1: count divisible by both.
- `in_count`, input, CNT_W: counter value for this event.
- `out_valid`, output, 1: `out_data` holds a byte.
- `out_ready`, input, 1: sink accepts the byte.
- `out_data`, output, 8: ASCII byte.
- `out_last`, output, 1: high with the terminating `\n` byte.
- `overflow`, output, 1: sticky. Set when an event was offered while `in_ready`=0.
- `busy`, output, 1: FIFO not empty or FSM not in IDLE.

## Operation
- **Event write.** An event is written on any edge where `in_valid && in_ready`.
  - `in_ready` = !full, based on registered state only.
  - When the FIFO is full, no write occurs, even if a pop happens on the same edge.
  - `in_valid && !in_ready` sets `overflow` and discards the event.
  - `overflow` clears only on reset.
- **Classification.** Applied on pop, in priority order:
  - `in_fizzbuzz`, or `in_fizz && in_buzz` → WORD "FizzBuzz".
  - else `in_fizz` → "Fizz".
  - else `in_buzz` → "Buzz".
  - else NUMBER.
- **FSM states:** IDLE, CONV, EMIT.
- **IDLE.**
  - FIFO not empty: pop at the edge.
  - WORD → EMIT.
  - NUMBER → CONV with the shift register loaded from the count and BCD cleared.
- **CONV.**
  - Double-dabble, one input bit per cycle, exactly CNT_W cycles.
  - Then → EMIT.
- **EMIT.**
  - Presents bytes in order. The byte index advances only on `out_valid && out_ready`.
  - After the `\n` byte is accepted → IDLE.
- **Byte values.**
  - F=0x46, i=0x69, z=0x7A, B=0x42, u=0x75, `\n`=0x0A.
  - Digit d=0x30+d.
  - "Fizz" = 46 69 7A 7A.
  - "Buzz" = 42 75 7A 7A.
  - "FizzBuzz" = "Fizz" followed by "Buzz".
- **Number formatting.**
  - Most significant digit first, leading zeros suppressed.
  - Count 0 emits 0x30.
  - Number lines carry 1..DIGITS digit bytes, then 0x0A.
- **AXI-style stream rule.** Once `out_valid` is high, `out_data` and `out_last` hold stable and `out_valid` stays high until accepted. `out_valid` never depends combinationally on `out_ready`.

## Timing
- **Reset** (edge with `resetn`=0):
  - FIFO emptied; FSM in IDLE.
  - `in_ready`=0 while `resetn` is low, 1 from the first cycle after release.
  - `out_valid`=0, `out_data`=0x00, `out_last`=0, `overflow`=0, `busy`=0.
- **Reset mid-line:** the partial line is abandoned with no trailing `\n`. The first post-reset line starts cleanly.
- **Word latency:** event written at edge N with the FIFO empty and FSM in IDLE → pop at edge N+1 → first byte valid from edge N+1.
- **Number latency:** pop at N+1, CONV for CNT_W edges, first byte valid after edge N+1+CNT_W. This is 9 cycles after write for CNT_W=8.
- **Throughput:** with `out_ready` held high, one byte per cycle within a line. There is one IDLE cycle between the accepted `\n` and the next pop.
- **Concurrency:** a pop and a write on the same edge are both performed. FIFO occupancy then stays unchanged, provided it was not full.
- **Count wrap:** the block does not track sequence. Each event is formatted from its own `in_count`.

## Test plan
- **Number line:** `in_count`=7, no flags → bytes 0x37, 0x0A. `out_last` high only on 0x0A. First byte valid 9 cycles after the write.
- **Fizz and FizzBuzz priority:**
  - `in_fizz`=1, count 3 → 46 69 7A 7A 0A.
  - `in_fizz`=`in_buzz`=1, `in_fizzbuzz`=0, count 15 → 46 69 7A 7A 42 75 7A 7A 0A.
- **Number boundaries:**
  - Count 0 → 30 0A.
  - Count 255 → 32 35 35 0A.
  - Count 10 → 31 30 0A.
- **Backpressure:** random `out_ready` toggling during "Buzz\n". `out_data` is held stable while not accepted. Exactly 42 75 7A 7A 0A is delivered.
- **Full FIFO:** with `out_ready`=0, offer 6 consecutive events at DEPTH=4.
  - The first FIFO write is popped, so `in_ready` drops after 5 accepts.
  - The 6th event sets `overflow`; `overflow` persists.
  - Releasing `out_ready` yields 5 complete lines in order.
- **Reset mid-line:** assert `resetn`=0 for one cycle during the 3rd byte of "FizzBuzz". The next cycle shows `out_valid`=0 and `busy`=0, then a fresh event emits its full line.

Source files
------------

// File: rtl/fizzbuzz_ascii_streamer.sv
`default_nettype none
// ============================================================================
// Module      : fizzbuzz_ascii_streamer
// Description : Buffers classified fizz/buzz count events in a small FIFO and
//               streams each as an ASCII line ("Fizz\n", "Buzz\n",
//               "FizzBuzz\n" or decimal count + "\n") on a valid/ready byte
//               interface. Numbers go through a serial double-dabble converter.
// Revision    : 1.0 - initial release
// ============================================================================
module fizzbuzz_ascii_streamer #(
  parameter int CNT_W = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_fizz,
  input  logic             in_buzz,
  input  logic             in_fizzbuzz,
  input  logic [CNT_W-1:0] in_count,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_last,
  output logic             overflow,
  output logic             busy
);

  // Decimal digits needed to print the largest count value
  function automatic int calc_digits(input int w);
    logic [31:0] v;
    int          n;
    v = (32'd1 << w) - 32'd1;
    n = 0;
    for (int k = 0; k < 10; k++) begin
      if (v != 32'd0) begin
        n = n + 1;
        v = v / 32'd10;
      end
    end
    return n;
  endfunction

  localparam int DIGITS = calc_digits(CNT_W);
  localparam int BCD_W  = 4 * DIGITS;
  localparam int AW     = $clog2(DEPTH);
  localparam int BW     = $clog2(CNT_W);
  localparam int ENT_W  = CNT_W + 3;

  localparam logic [BW-1:0] c_last_bit = BW'(CNT_W - 1);
  localparam logic [3:0]    c_digits   = 4'(DIGITS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CONV = 2'd1;
  localparam logic [1:0] S_EMIT = 2'd2;

  localparam logic [1:0] K_NUM  = 2'd0;
  localparam logic [1:0] K_FIZZ = 2'd1;
  localparam logic [1:0] K_BUZZ = 2'd2;
  localparam logic [1:0] K_FB   = 2'd3;

  localparam logic [7:0] c_ch_f  = 8'h46;
  localparam logic [7:0] c_ch_i  = 8'h69;
  localparam logic [7:0] c_ch_z  = 8'h7A;
  localparam logic [7:0] c_ch_b  = 8'h42;
  localparam logic [7:0] c_ch_u  = 8'h75;
  localparam logic [7:0] c_ch_nl = 8'h0A;

  // ---------------------------------------------------------------- FIFO
  logic [ENT_W-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             r_rdy_en;
  logic             r_overflow;
  logic             w_empty;
  logic             w_full;
  logic             w_wr;
  logic             w_pop;
  logic [ENT_W-1:0] w_head;
  logic [1:0]       w_head_kind;

  // ---------------------------------------------------------------- FSM / datapath
  logic [1:0]       r_state;
  logic [1:0]       w_next_state;
  logic [1:0]       r_kind;
  logic [CNT_W-1:0] r_shift;
  logic [BCD_W-1:0] r_bcd;
  logic [BCD_W-1:0] w_bcd_adj;
  logic [BCD_W-1:0] w_bcd_next;
  logic [BW-1:0]    r_bitcnt;
  logic [3:0]       r_idx;
  logic [3:0]       w_lead;
  logic             w_seen;
  logic [3:0]       w_pos;
  logic [7:0]       w_byte;
  logic             w_last;

  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  // r_rdy_en keeps in_ready low throughout reset and until the first
  // clock after release, independent of the pointer state.
  assign in_ready = r_rdy_en && !w_full;
  assign w_wr     = in_valid && in_ready;
  assign w_pop    = (r_state == S_IDLE) && !w_empty;
  assign w_head   = r_mem[r_rd_ptr[AW-1:0]];
  assign overflow = r_overflow;
  assign busy     = !w_empty || (r_state != S_IDLE);

  // Head entry layout: {fizzbuzz, fizz, buzz, count}; FizzBuzz wins over both
  always_comb begin
    w_head_kind = K_NUM;
    if (w_head[ENT_W-1] || (w_head[ENT_W-2] && w_head[ENT_W-3])) begin
      w_head_kind = K_FB;
    end else if (w_head[ENT_W-2]) begin
      w_head_kind = K_FIZZ;
    end else if (w_head[ENT_W-3]) begin
      w_head_kind = K_BUZZ;
    end
  end

  // Event storage (data only, no reset needed)
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr[AW-1:0]] <= {in_fizzbuzz, in_fizz, in_buzz, in_count};
    end
  end

  // FIFO pointers, ready enable and sticky overflow
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_rdy_en   <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_rdy_en <= 1'b1;
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (in_valid && !in_ready) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Double-dabble step: add 3 to any digit >= 5, then shift in the next bit
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int d = 0; d < DIGITS; d++) begin
      if (r_bcd[4*d +: 4] >= 4'd5) begin
        w_bcd_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
      end
    end
    w_bcd_next = {w_bcd_adj[BCD_W-2:0], r_shift[CNT_W-1]};
  end

  // Leading-zero digits to skip; the units digit is always printed
  always_comb begin
    w_lead = 4'd0;
    w_seen = 1'b0;
    for (int d = DIGITS - 1; d >= 1; d--) begin
      if (!w_seen && (r_bcd[4*d +: 4] == 4'd0)) begin
        w_lead = w_lead + 4'd1;
      end else begin
        w_seen = 1'b1;
      end
    end
    w_pos = w_lead + r_idx;
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_next_state = (w_head_kind == K_NUM) ? S_CONV : S_EMIT;
        end
      end
      S_CONV: begin
        if (r_bitcnt == c_last_bit) begin
          w_next_state = S_EMIT;
        end
      end
      S_EMIT: begin
        if (out_ready && w_last) begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // FSM outputs: current byte and end-of-line marker, all from registers
  always_comb begin
    w_byte = 8'h00;
    w_last = 1'b0;
    if (r_state == S_EMIT) begin
      case (r_kind)
        K_NUM: begin
          if (w_pos >= c_digits) begin
            w_byte = c_ch_nl;
            w_last = 1'b1;
          end else begin
            for (int d = 0; d < DIGITS; d++) begin
              if (w_pos == 4'(DIGITS - 1 - d)) begin
                w_byte = {4'h3, r_bcd[4*d +: 4]};
              end
            end
          end
        end
        K_FIZZ: begin
          case (r_idx)
            4'd0:      w_byte = c_ch_f;
            4'd1:      w_byte = c_ch_i;
            4'd2, 4'd3: w_byte = c_ch_z;
            default: begin
              w_byte = c_ch_nl;
              w_last = 1'b1;
            end
          endcase
        end
        K_BUZZ: begin
          case (r_idx)
            4'd0:      w_byte = c_ch_b;
            4'd1:      w_byte = c_ch_u;
            4'd2, 4'd3: w_byte = c_ch_z;
            default: begin
              w_byte = c_ch_nl;
              w_last = 1'b1;
            end
          endcase
        end
        default: begin
          case (r_idx)
            4'd0:      w_byte = c_ch_f;
            4'd1:      w_byte = c_ch_i;
            4'd2, 4'd3: w_byte = c_ch_z;
            4'd4:      w_byte = c_ch_b;
            4'd5:      w_byte = c_ch_u;
            4'd6, 4'd7: w_byte = c_ch_z;
            default: begin
              w_byte = c_ch_nl;
              w_last = 1'b1;
            end
          endcase
        end
      endcase
    end
    out_valid = (r_state == S_EMIT);
    out_data  = w_byte;
    out_last  = w_last;
  end

  // Line datapath: load on pop, convert in CONV, step byte index in EMIT
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_kind   <= K_NUM;
      r_shift  <= '0;
      r_bcd    <= '0;
      r_bitcnt <= '0;
      r_idx    <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_kind   <= w_head_kind;
            r_shift  <= w_head[CNT_W-1:0];
            r_bcd    <= '0;
            r_bitcnt <= '0;
            r_idx    <= 4'd0;
          end
        end
        S_CONV: begin
          r_bcd    <= w_bcd_next;
          r_shift  <= {r_shift[CNT_W-2:0], 1'b0};
          r_bitcnt <= r_bitcnt + 1'b1;
        end
        S_EMIT: begin
          if (out_ready && !w_last) begin
            r_idx <= r_idx + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fizzbuzz_ascii_streamer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fizzbuzz_ascii_streamer
// Description : Directed, table-driven bench for fizzbuzz_ascii_streamer with
//               hand sequences for backpressure, full FIFO and mid-line reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fizzbuzz_ascii_streamer;

  localparam int CNT_W = 8;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             in_fizz = 1'b0;
  logic             in_buzz = 1'b0;
  logic             in_fizzbuzz = 1'b0;
  logic [CNT_W-1:0] in_count = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [7:0]       out_data;
  logic             out_last;
  logic             overflow;
  logic             busy;

  fizzbuzz_ascii_streamer #(.CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_fizz    (in_fizz),
    .in_buzz    (in_buzz),
    .in_fizzbuzz(in_fizzbuzz),
    .in_count   (in_count),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .overflow   (overflow),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic        f;
    logic        b;
    logic        fb;
    logic [7:0]  cnt;
    int          len;
    int          lat;
    logic [71:0] seq;   // byte 0 in bits [71:64]
  } vec_t;

  vec_t tbl [10];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn   = 1'b0;
    in_valid = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    tick();
  endtask

  task automatic send(input logic f, input logic b, input logic fb, input logic [7:0] c);
    in_valid    = 1'b1;
    in_fizz     = f;
    in_buzz     = b;
    in_fizzbuzz = fb;
    in_count    = c;
    tick();
    in_valid    = 1'b0;
    in_fizz     = 1'b0;
    in_buzz     = 1'b0;
    in_fizzbuzz = 1'b0;
  endtask

  logic [7:0] got [$];
  logic [7:0] exp_q [$];
  logic [7:0] held;
  logic       hold_pending;
  logic       done;
  int         lat;
  int         lines;

  initial begin
    tbl[0] = '{1'b0, 1'b0, 1'b0, 8'd7,   2, 9, 72'h37_0A_00_00_00_00_00_00_00};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 8'd3,   5, 1, 72'h46_69_7A_7A_0A_00_00_00_00};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 8'd15,  9, 1, 72'h46_69_7A_7A_42_75_7A_7A_0A};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 8'd0,   2, 9, 72'h30_0A_00_00_00_00_00_00_00};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 8'd255, 4, 9, 72'h32_35_35_0A_00_00_00_00_00};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 8'd10,  3, 9, 72'h31_30_0A_00_00_00_00_00_00};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 8'd5,   5, 1, 72'h42_75_7A_7A_0A_00_00_00_00};
    tbl[7] = '{1'b0, 1'b0, 1'b1, 8'd30,  9, 1, 72'h46_69_7A_7A_42_75_7A_7A_0A};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 8'd100, 4, 9, 72'h31_30_30_0A_00_00_00_00_00};
    tbl[9] = '{1'b1, 1'b0, 1'b1, 8'd45,  9, 1, 72'h46_69_7A_7A_42_75_7A_7A_0A};

    // Reset state
    resetn = 1'b0;
    tick();
    tick();
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_out_last", int'(out_last), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_busy", int'(busy), 0);
    resetn = 1'b1;
    tick();
    check("rst_release_in_ready", int'(in_ready), 1);

    // Table of single-event lines, sink always ready
    out_ready = 1'b1;
    for (int v = 0; v < 10; v++) begin
      send(tbl[v].f, tbl[v].b, tbl[v].fb, tbl[v].cnt);
      lat = 0;
      while (!out_valid && lat < 50) begin
        tick();
        lat++;
      end
      check($sformatf("v%0d_latency", v), lat, tbl[v].lat);
      for (int i = 0; i < tbl[v].len; i++) begin
        check($sformatf("v%0d_valid%0d", v, i), int'(out_valid), 1);
        check($sformatf("v%0d_byte%0d", v, i), int'(out_data), int'(tbl[v].seq[71-8*i -: 8]));
        check($sformatf("v%0d_last%0d", v, i), int'(out_last), (i == tbl[v].len - 1) ? 1 : 0);
        tick();
      end
      check($sformatf("v%0d_idle_valid", v), int'(out_valid), 0);
      check($sformatf("v%0d_idle_busy", v), int'(busy), 0);
    end

    // Backpressure on "Buzz\n" with random out_ready
    send(1'b0, 1'b1, 1'b0, 8'd5);
    got.delete();
    hold_pending = 1'b0;
    held = 8'h00;
    done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      if (hold_pending) begin
        check("bp_valid_held", int'(out_valid), 1);
        check("bp_data_held", int'(out_data), int'(held));
      end
      out_ready = 1'($urandom_range(0, 1));
      if (out_valid && out_ready) begin
        got.push_back(out_data);
        if (out_last) done = 1'b1;
      end
      hold_pending = out_valid && !out_ready;
      held = out_data;
      tick();
    end
    out_ready = 1'b1;
    exp_q = '{8'h42, 8'h75, 8'h7A, 8'h7A, 8'h0A};
    check("bp_done", int'(done), 1);
    check("bp_len", got.size(), 5);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_byte%0d", i), (i < got.size()) ? int'(got[i]) : 'hFFF, int'(exp_q[i]));
    end

    // Full FIFO: six back-to-back events with the sink stalled
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      case (i)
        0: begin in_fizz = 0; in_buzz = 0; in_fizzbuzz = 0; in_count = 8'd1;  end
        1: begin in_fizz = 1; in_buzz = 0; in_fizzbuzz = 0; in_count = 8'd3;  end
        2: begin in_fizz = 0; in_buzz = 1; in_fizzbuzz = 0; in_count = 8'd5;  end
        3: begin in_fizz = 0; in_buzz = 0; in_fizzbuzz = 0; in_count = 8'd7;  end
        4: begin in_fizz = 0; in_buzz = 0; in_fizzbuzz = 1; in_count = 8'd15; end
        default: begin in_fizz = 0; in_buzz = 0; in_fizzbuzz = 0; in_count = 8'd8; end
      endcase
      check($sformatf("ff_in_ready%0d", i), int'(in_ready), (i < 5) ? 1 : 0);
      check($sformatf("ff_overflow_pre%0d", i), int'(overflow), 0);
      tick();
    end
    in_valid = 1'b0;
    in_fizz = 1'b0;
    in_buzz = 1'b0;
    in_fizzbuzz = 1'b0;
    check("ff_overflow_set", int'(overflow), 1);
    for (int i = 0; i < 10; i++) tick();
    check("ff_overflow_sticky", int'(overflow), 1);
    check("ff_still_full", int'(in_ready), 0);
    check("ff_stalled_valid", int'(out_valid), 1);
    check("ff_stalled_byte", int'(out_data), 8'h31);
    out_ready = 1'b1;
    got.delete();
    lines = 0;
    for (int c = 0; c < 400 && lines < 5; c++) begin
      if (out_valid) begin
        got.push_back(out_data);
        if (out_last) lines++;
      end
      tick();
    end
    exp_q = '{8'h31, 8'h0A,
              8'h46, 8'h69, 8'h7A, 8'h7A, 8'h0A,
              8'h42, 8'h75, 8'h7A, 8'h7A, 8'h0A,
              8'h37, 8'h0A,
              8'h46, 8'h69, 8'h7A, 8'h7A, 8'h42, 8'h75, 8'h7A, 8'h7A, 8'h0A};
    check("ff_lines", lines, 5);
    check("ff_len", got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      check($sformatf("ff_byte%0d", i), (i < got.size()) ? int'(got[i]) : 'hFFF, int'(exp_q[i]));
    end
    for (int i = 0; i < 3; i++) tick();
    check("ff_drained_busy", int'(busy), 0);
    check("ff_overflow_final", int'(overflow), 1);

    // Reset during the third byte of "FizzBuzz"
    do_reset();
    check("mr_overflow_cleared", int'(overflow), 0);
    out_ready = 1'b1;
    send(1'b1, 1'b1, 1'b0, 8'd15);
    lat = 0;
    while (!out_valid && lat < 50) begin
      tick();
      lat++;
    end
    check("mr_byte0", int'(out_data), 8'h46);
    tick();
    tick();
    check("mr_byte2", int'(out_data), 8'h7A);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    check("mr_out_valid", int'(out_valid), 0);
    check("mr_busy", int'(busy), 0);
    check("mr_out_data", int'(out_data), 0);
    check("mr_in_ready_low", int'(in_ready), 0);
    tick();
    check("mr_in_ready_high", int'(in_ready), 1);
    send(1'b1, 1'b0, 1'b0, 8'd3);
    lat = 0;
    while (!out_valid && lat < 50) begin
      tick();
      lat++;
    end
    check("mr_new_latency", lat, 1);
    exp_q = '{8'h46, 8'h69, 8'h7A, 8'h7A, 8'h0A};
    for (int i = 0; i < 5; i++) begin
      check($sformatf("mr_new_byte%0d", i), int'(out_data), int'(exp_q[i]));
      check($sformatf("mr_new_last%0d", i), int'(out_last), (i == 4) ? 1 : 0);
      tick();
    end
    check("mr_new_idle", int'(out_valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
